// File: rtl/rom_arb.sv
// rom_arb: shares one asynchronous ROM read port among CLIENTS requesters with a 2-stage read pipeline.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration; undefined gives fixed priority (lowest index wins).
module rom_arb #(
  parameter int CLIENTS = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [CLIENTS-1:0]               req,
  input  logic [CLIENTS*$clog2(DEPTH)-1:0] addr,
  output logic [CLIENTS-1:0]               ack,
  output logic [$clog2(DEPTH)-1:0]         rom_addr,
  input  logic [WIDTH-1:0]                 rom_data,
  output logic [CLIENTS-1:0]               rvalid,
  output logic [WIDTH-1:0]                 rdata,
  output logic                             busy
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int IDW   = $clog2(CLIENTS);

  logic [IDW-1:0]     ptr_base;
  logic               win_found;
  int                 win_int;
  logic [IDW-1:0]     win_id;
  logic               xfer;

  logic [ADDRW-1:0]   rom_addr_q, rom_addr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [IDW-1:0]     s1_id_q, s1_id_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [CLIENTS-1:0] rvalid_q, rvalid_d;

  // Scan upward from the pointer with wrap-around; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_int   = 0;
    for (int k = 0; k < CLIENTS; k++) begin
      if (!win_found && req[(int'(ptr_base) + k) % CLIENTS]) begin
        win_found = 1'b1;
        win_int   = (int'(ptr_base) + k) % CLIENTS;
      end
    end
    win_id = IDW'(win_int);
    xfer   = win_found && en && !rst;
    ack    = xfer ? (CLIENTS'(1) << win_id) : '0;
  end

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = IDW'((win_int + 1) % CLIENTS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_base = ptr_q;
`else
  assign ptr_base = '0;
`endif

  // Stage 1: latch the winning address toward the ROM.
  always_comb begin
    rom_addr_d = rom_addr_q;
    s1_valid_d = xfer;
    s1_id_d    = s1_id_q;
    if (xfer) begin
      rom_addr_d = addr[win_int*ADDRW +: ADDRW];
      s1_id_d    = win_id;
    end
  end

  // Stage 2: capture ROM output and strobe the owning client.
  always_comb begin
    rdata_d  = rom_data;
    rvalid_d = s1_valid_q ? (CLIENTS'(1) << s1_id_q) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign busy     = s1_valid_q || (|rvalid_q);

endmodule

// File: tb/tb_rom_arb.sv
// Directed bench for rom_arb (CLIENTS=4, WIDTH=8, DEPTH=256), ROM modelled as data[a] = a ^ 8'hA5.
// Expectations follow ROM_ARB_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_rom_arb;
  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [31:0] addr;
  logic [3:0]  ack;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  rvalid;
  logic [7:0]  rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rom_arb #(.CLIENTS(4), .WIDTH(8), .DEPTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .addr     (addr),
    .ack      (ack),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .busy     (busy)
  );

  assign rom_data = rom_addr ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic        en;
    logic [3:0]  req;
    logic [31:0] addr;
    logic [3:0]  ack;
    logic [7:0]  rom_addr;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rb, input logic e, input logic [3:0] rq, input logic [31:0] a,
                     input logic [3:0] xack, input logic [7:0] xra, input logic [3:0] xrv,
                     input logic [7:0] xrd, input logic xb);
    vec_t v;
    v.rst_before = rb; v.en = e; v.req = rq; v.addr = a;
    v.ack = xack; v.rom_addr = xra; v.rvalid = xrv; v.rdata = xrd; v.busy = xb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; req = 4'b1111; en = 1'b1; addr = 32'h0;
    @(negedge clk);
    chk("rst_ack", {28'h0, ack}, 32'h0);
    chk("rst_rvalid", {28'h0, rvalid}, 32'h0);
    chk("rst_rdata", {24'h0, rdata}, 32'h0);
    chk("rst_rom_addr", {24'h0, rom_addr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    step();
    step();
    rst = 1'b0; req = 4'b0000;
  endtask

  localparam logic [31:0] T1A = 32'h00100000;
  localparam logic [31:0] T2A = 32'h03020100;
  localparam logic [31:0] T3A = 32'h33221100;
  localparam logic [31:0] T4A = 32'h00000040;

  logic [3:0] exp_ack;

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0; addr = 32'h0;

    // single read from client 2
    add(1, 1, 4'b0100, T1A, 4'b0100, 8'h00, 4'b0000, 8'h00, 0);
    add(0, 1, 4'b0000, T1A, 4'b0000, 8'h10, 4'b0000, 8'h00, 1);
    add(0, 1, 4'b0000, T1A, 4'b0000, 8'h10, 4'b0100, 8'hB5, 1);
    add(0, 1, 4'b0000, T1A, 4'b0000, 8'h10, 4'b0000, 8'h00, 0);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    // full contention rotates 0,1,2,3,0,1
    add(1, 1, 4'b1111, T2A, 4'b0001, 8'h00, 4'b0000, 8'h00, 0);
    add(0, 1, 4'b1111, T2A, 4'b0010, 8'h00, 4'b0000, 8'h00, 1);
    add(0, 1, 4'b1111, T2A, 4'b0100, 8'h01, 4'b0001, 8'hA5, 1);
    add(0, 1, 4'b1111, T2A, 4'b1000, 8'h02, 4'b0010, 8'hA4, 1);
    add(0, 1, 4'b1111, T2A, 4'b0001, 8'h03, 4'b0100, 8'hA7, 1);
    add(0, 1, 4'b1111, T2A, 4'b0010, 8'h00, 4'b1000, 8'hA6, 1);
    add(0, 1, 4'b0000, T2A, 4'b0000, 8'h01, 4'b0001, 8'hA5, 1);
    add(0, 1, 4'b0000, T2A, 4'b0000, 8'h01, 4'b0010, 8'hA4, 1);
    add(0, 1, 4'b0000, T2A, 4'b0000, 8'h01, 4'b0000, 8'h00, 0);
    // grant 2 moves ptr to 3, then clients 1 and 3: 3,1,3
    add(1, 1, 4'b0100, T3A, 4'b0100, 8'h00, 4'b0000, 8'h00, 0);
    add(0, 1, 4'b1010, T3A, 4'b1000, 8'h22, 4'b0000, 8'h00, 1);
    add(0, 1, 4'b1010, T3A, 4'b0010, 8'h33, 4'b0100, 8'h87, 1);
    add(0, 1, 4'b1010, T3A, 4'b1000, 8'h11, 4'b1000, 8'h96, 1);
    add(0, 1, 4'b0000, T3A, 4'b0000, 8'h33, 4'b0010, 8'hB4, 1);
    add(0, 1, 4'b0000, T3A, 4'b0000, 8'h33, 4'b1000, 8'h96, 1);
    add(0, 1, 4'b0000, T3A, 4'b0000, 8'h33, 4'b0000, 8'h00, 0);
`else
    // full contention: client 0 always wins
    add(1, 1, 4'b1111, T2A, 4'b0001, 8'h00, 4'b0000, 8'h00, 0);
    add(0, 1, 4'b1111, T2A, 4'b0001, 8'h00, 4'b0000, 8'h00, 1);
    add(0, 1, 4'b1111, T2A, 4'b0001, 8'h00, 4'b0001, 8'hA5, 1);
    add(0, 1, 4'b1111, T2A, 4'b0001, 8'h00, 4'b0001, 8'hA5, 1);
    add(0, 1, 4'b1111, T2A, 4'b0001, 8'h00, 4'b0001, 8'hA5, 1);
    add(0, 1, 4'b1111, T2A, 4'b0001, 8'h00, 4'b0001, 8'hA5, 1);
    add(0, 1, 4'b0000, T2A, 4'b0000, 8'h00, 4'b0001, 8'hA5, 1);
    add(0, 1, 4'b0000, T2A, 4'b0000, 8'h00, 4'b0001, 8'hA5, 1);
    add(0, 1, 4'b0000, T2A, 4'b0000, 8'h00, 4'b0000, 8'h00, 0);
    // clients 1 and 3: client 1 always wins
    add(1, 1, 4'b0100, T3A, 4'b0100, 8'h00, 4'b0000, 8'h00, 0);
    add(0, 1, 4'b1010, T3A, 4'b0010, 8'h22, 4'b0000, 8'h00, 1);
    add(0, 1, 4'b1010, T3A, 4'b0010, 8'h11, 4'b0100, 8'h87, 1);
    add(0, 1, 4'b1010, T3A, 4'b0010, 8'h11, 4'b0010, 8'hB4, 1);
    add(0, 1, 4'b0000, T3A, 4'b0000, 8'h11, 4'b0010, 8'hB4, 1);
    add(0, 1, 4'b0000, T3A, 4'b0000, 8'h11, 4'b0010, 8'hB4, 1);
    add(0, 1, 4'b0000, T3A, 4'b0000, 8'h11, 4'b0000, 8'h00, 0);
`endif
    // enable gating: read accepted just before en falls still returns
    add(1, 1, 4'b0001, T4A, 4'b0001, 8'h00, 4'b0000, 8'h00, 0);
    add(0, 0, 4'b0001, T4A, 4'b0000, 8'h40, 4'b0000, 8'h00, 1);
    add(0, 0, 4'b0001, T4A, 4'b0000, 8'h40, 4'b0001, 8'hE5, 1);
    add(0, 0, 4'b0001, T4A, 4'b0000, 8'h40, 4'b0000, 8'h00, 0);
    add(0, 0, 4'b0001, T4A, 4'b0000, 8'h40, 4'b0000, 8'h00, 0);
    add(0, 0, 4'b0001, T4A, 4'b0000, 8'h40, 4'b0000, 8'h00, 0);
    add(0, 1, 4'b0001, T4A, 4'b0001, 8'h40, 4'b0000, 8'h00, 0);
    add(0, 1, 4'b0000, T4A, 4'b0000, 8'h40, 4'b0000, 8'h00, 1);
    add(0, 1, 4'b0000, T4A, 4'b0000, 8'h40, 4'b0001, 8'hE5, 1);
    add(0, 1, 4'b0000, T4A, 4'b0000, 8'h40, 4'b0000, 8'h00, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      step();
      en = vecs[i].en; req = vecs[i].req; addr = vecs[i].addr;
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), {28'h0, ack}, {28'h0, vecs[i].ack});
      chk($sformatf("v%0d_rom_addr", i), {24'h0, rom_addr}, {24'h0, vecs[i].rom_addr});
      chk($sformatf("v%0d_rvalid", i), {28'h0, rvalid}, {28'h0, vecs[i].rvalid});
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].busy});
      if (vecs[i].rvalid != 4'b0000)
        chk($sformatf("v%0d_rdata", i), {24'h0, rdata}, {24'h0, vecs[i].rdata});
    end

    // reset one cycle after a handshake discards the read
    do_reset();
    step();
    en = 1'b1; req = 4'b1000; addr = 32'h5A000000;
    @(negedge clk);
    chk("mid_ack_T", {28'h0, ack}, 32'h8);
    step();
    rst = 1'b1; req = 4'b0000;
    @(negedge clk);
    chk("mid_rvalid_T1", {28'h0, rvalid}, 32'h0);
    chk("mid_rdata_T1", {24'h0, rdata}, 32'h0);
    chk("mid_rom_addr_T1", {24'h0, rom_addr}, 32'h0);
    chk("mid_busy_T1", {31'h0, busy}, 32'h0);
    step();
    req = 4'b1000;
    @(negedge clk);
    chk("mid_ack_in_rst", {28'h0, ack}, 32'h0);
    chk("mid_rvalid_T2", {28'h0, rvalid}, 32'h0);
    chk("mid_rdata_T2", {24'h0, rdata}, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_ack", {28'h0, ack}, 32'h8);
    chk("post_rvalid0", {28'h0, rvalid}, 32'h0);
    step();
    req = 4'b0000;
    @(negedge clk);
    chk("post_rom_addr", {24'h0, rom_addr}, 32'h5A);
    chk("post_busy", {31'h0, busy}, 32'h1);
    step();
    @(negedge clk);
    chk("post_rvalid", {28'h0, rvalid}, 32'h8);
    chk("post_rdata", {24'h0, rdata}, 32'hFF);
    step();
    @(negedge clk);
    chk("post_idle_busy", {31'h0, busy}, 32'h0);

    // clients 0 and 3 requesting continuously
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step();
      en = 1'b1; req = 4'b1001; addr = 32'h30000000;
      @(negedge clk);
`ifdef ROM_ARB_ROUND_ROBIN_EN
      exp_ack = (c % 2 == 0) ? 4'b0001 : 4'b1000;
`else
      exp_ack = 4'b0001;
`endif
      chk($sformatf("pri_ack_%0d", c), {28'h0, ack}, {28'h0, exp_ack});
    end
    step();
    req = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
